// File: rtl/user_sync_fifo_if.sv
// Handshake/status bundle for user_sync_fifo.
// The master side (producer/consumer logic) drives the requests and write data.
// The slave side (the FIFO) drives read data and status.
interface user_sync_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wdata, rd_en,
    input  rdata, rvalid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wdata, rd_en,
    output rdata, rvalid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/user_sync_fifo.sv
// Single-clock FIFO around an inferred simple dual-port RAM.
// Read latency is 1 (OUTPUT_REG="FALSE") or 2 (OUTPUT_REG="TRUE") cycles.
// All status flags are registered from the next occupancy value, so no
// request input has a combinational path to any output.
module user_sync_fifo #(
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = 9,
  parameter string OUTPUT_REG = "TRUE",
  parameter int    AF_LEVEL   = (1 << ADDR_WIDTH) - 4,
  parameter int    AE_LEVEL   = 4
) (
  input logic             clk,
  input logic             rst,
  user_sync_fifo_if.slave bus
);

  localparam int DEPTH    = 1 << ADDR_WIDTH;
  localparam bit USE_OREG = (OUTPUT_REG == "TRUE");

  typedef logic [ADDR_WIDTH:0]   cnt_t;
  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t AF_C    = cnt_t'(AF_LEVEL);
  localparam cnt_t AE_C    = cnt_t'(AE_LEVEL);

  data_t mem [DEPTH];

  ptr_t  wptr_q, wptr_d;
  ptr_t  rptr_q, rptr_d;
  cnt_t  count_q, count_d;
  logic  full_q, full_d;
  logic  empty_q, empty_d;
  logic  afull_q, afull_d;
  logic  aempty_q, aempty_d;
  logic  ovf_q, ovf_d;
  logic  udf_q, udf_d;

  // Stage 1 is the RAM read register; its valid bit travels alongside it.
  data_t s1_data_q;
  logic  s1_valid_q, s1_valid_d;

  logic  wr_acc;
  logic  rd_acc;

  // Accept decisions, pointer/count update and next-state flag derivation.
  // Accepts look only at the registered flags, so a full FIFO rejects a
  // write even when a read drains a slot in the same cycle, and vice versa.
  always_comb begin
    wr_acc   = bus.wr_en & ~full_q;
    rd_acc   = bus.rd_en & ~empty_q;

    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;

    if (wr_acc) wptr_d = wptr_q + ptr_t'(1);
    if (rd_acc) rptr_d = rptr_q + ptr_t'(1);

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase

    full_d     = (count_d == DEPTH_C);
    empty_d    = (count_d == '0);
    afull_d    = (count_d >= AF_C);
    aempty_d   = (count_d <= AE_C);

    ovf_d      = ovf_q | (bus.wr_en & full_q);
    udf_d      = udf_q | (bus.rd_en & empty_q);

    s1_valid_d = rd_acc;
  end

  // Control registers: pointers, occupancy, status and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      s1_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      s1_valid_q <= s1_valid_d;
    end
  end

  // RAM write port and registered read port. Contents are never cleared;
  // only the read register resets so rdata starts at zero. Read and write
  // addresses can only match when empty or full, where one side is blocked,
  // so no write-to-read bypass is needed.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr_q] <= bus.wdata;
    if (rst) begin
      s1_data_q <= '0;
    end else if (rd_acc) begin
      s1_data_q <= mem[rptr_q];
    end
  end

  generate
    if (USE_OREG) begin : g_oreg
      data_t s2_data_q, s2_data_d;
      logic  s2_valid_q, s2_valid_d;

      // Second output stage: load only on a valid stage-1 word so rdata holds.
      always_comb begin
        s2_data_d  = s2_data_q;
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) s2_data_d = s1_data_q;
      end

      // Output register; reset discards any read still in the pipeline.
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_data_q  <= '0;
          s2_valid_q <= 1'b0;
        end else begin
          s2_data_q  <= s2_data_d;
          s2_valid_q <= s2_valid_d;
        end
      end

      assign bus.rdata  = s2_data_q;
      assign bus.rvalid = s2_valid_q;
    end else begin : g_noreg
      assign bus.rdata  = s1_data_q;
      assign bus.rvalid = s1_valid_q;
    end
  endgenerate

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_user_sync_fifo.sv
// Bench for user_sync_fifo: two DEPTH=8 instances (read latency 1 and 2)
// share one stimulus stream; a queue model predicts data and status.
module tb_user_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] wdata;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  always #5 clk = ~clk;

  user_sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus_f ();
  user_sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus_t ();

  assign bus_f.wr_en = wr_en;
  assign bus_f.rd_en = rd_en;
  assign bus_f.wdata = wdata;
  assign bus_t.wr_en = wr_en;
  assign bus_t.rd_en = rd_en;
  assign bus_t.wdata = wdata;

  user_sync_fifo #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .OUTPUT_REG("FALSE"),
    .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut_f (
    .clk(clk), .rst(rst), .bus(bus_f)
  );

  user_sync_fifo #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .OUTPUT_REG("TRUE"),
    .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut_t (
    .clk(clk), .rst(rst), .bus(bus_t)
  );

  // Reference model
  logic [3:0] m_count;
  logic       m_ovf;
  logic       m_udf;
  logic       m_wa;
  logic       m_ra;
  int         n_wr_acc = 0;
  logic [7:0] mfifo[$];
  logic [7:0] exp_f[$];
  logic [7:0] exp_t[$];
  logic [7:0] pop_v;

  assign m_wa = wr_en && (m_count != 4'd8);
  assign m_ra = rd_en && (m_count != 4'd0);

  always @(posedge clk) begin
    if (rst) begin
      m_count <= 4'd0;
      m_ovf   <= 1'b0;
      m_udf   <= 1'b0;
      mfifo.delete();
      exp_f.delete();
      exp_t.delete();
    end else begin
      if (m_ra) begin
        pop_v = mfifo.pop_front();
        exp_f.push_back(pop_v);
        exp_t.push_back(pop_v);
      end
      if (m_wa) begin
        mfifo.push_back(wdata);
        n_wr_acc <= n_wr_acc + 1;
      end
      if (m_wa && !m_ra) m_count <= m_count + 4'd1;
      else if (m_ra && !m_wa) m_count <= m_count - 4'd1;
      if (wr_en && m_count == 4'd8) m_ovf <= 1'b1;
      if (rd_en && m_count == 4'd0) m_udf <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle status comparison and scoreboard pop on rvalid.
  always @(negedge clk) begin
    if (mon_en) begin
      check("status_f",
            32'({bus_f.count, bus_f.full, bus_f.empty, bus_f.almost_full,
                 bus_f.almost_empty, bus_f.overflow, bus_f.underflow}),
            32'({m_count, m_count == 4'd8, m_count == 4'd0, m_count >= 4'd6,
                 m_count <= 4'd2, m_ovf, m_udf}));
      check("status_t",
            32'({bus_t.count, bus_t.full, bus_t.empty, bus_t.almost_full,
                 bus_t.almost_empty, bus_t.overflow, bus_t.underflow}),
            32'({m_count, m_count == 4'd8, m_count == 4'd0, m_count >= 4'd6,
                 m_count <= 4'd2, m_ovf, m_udf}));
      if (bus_f.rvalid !== 1'b0) begin
        if (exp_f.size() == 0) check("unexpected_rvalid_f", 32'(bus_f.rvalid), 32'd0);
        else check("rdata_f", 32'(bus_f.rdata), 32'(exp_f.pop_front()));
      end
      if (bus_t.rvalid !== 1'b0) begin
        if (exp_t.size() == 0) check("unexpected_rvalid_t", 32'(bus_t.rvalid), 32'd0);
        else check("rdata_t", 32'(bus_t.rdata), 32'(exp_t.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int start;
    int cyc;

    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wdata = 8'h00;
    repeat (3) tick();
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("reset_rvalid_f", 32'(bus_f.rvalid), 32'd0);
    check("reset_rvalid_t", 32'(bus_t.rvalid), 32'd0);
    check("reset_rdata_f",  32'(bus_f.rdata),  32'd0);
    check("reset_rdata_t",  32'(bus_t.rdata),  32'd0);
    check("reset_empty_f",  32'({bus_f.empty, bus_f.almost_empty, bus_f.full}), 32'b110);

    // Fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1;
      wdata = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    @(negedge clk);
    check("fill_full_f",  32'(bus_f.full),  32'd1);
    check("fill_count_t", 32'(bus_t.count), 32'd8);

    // Write + read at full: only the read goes through
    wr_en = 1'b1;
    rd_en = 1'b1;
    wdata = 8'h99;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    check("full_wr_rd_count", 32'(bus_f.count),    32'd7);
    check("full_wr_rd_ovf",   32'(bus_t.overflow), 32'd1);

    // Drain the remaining seven
    rd_en = 1'b1;
    repeat (7) tick();
    rd_en = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("drain_empty_f", 32'(bus_f.empty), 32'd1);
    check("drain_empty_t", 32'(bus_t.empty), 32'd1);

    // Read + write at empty: only the write goes through
    wr_en = 1'b1;
    rd_en = 1'b1;
    wdata = 8'h55;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    check("empty_wr_rd_count", 32'(bus_f.count),     32'd1);
    check("empty_wr_rd_udf",   32'(bus_t.underflow), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("empty_rd_no_rvalid_f", 32'(bus_f.rvalid), 32'd0);
      check("empty_rd_no_rvalid_t", 32'(bus_t.rvalid), 32'd0);
      tick();
      @(negedge clk);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    repeat (3) tick();

    // Latency: one write of 0xA5, one read pulse
    wr_en = 1'b1;
    wdata = 8'hA5;
    tick();
    wr_en = 1'b0;
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    @(negedge clk);
    check("lat1_rvalid_f", 32'(bus_f.rvalid), 32'd1);
    check("lat1_rdata_f",  32'(bus_f.rdata),  32'hA5);
    check("lat1_rvalid_t", 32'(bus_t.rvalid), 32'd0);
    tick();
    @(negedge clk);
    check("lat2_rvalid_f", 32'(bus_f.rvalid), 32'd0);
    check("lat2_rdata_hold_f", 32'(bus_f.rdata), 32'hA5);
    check("lat2_rvalid_t", 32'(bus_t.rvalid), 32'd1);
    check("lat2_rdata_t",  32'(bus_t.rdata),  32'hA5);
    repeat (2) tick();

    // Random stream of 40 accepted writes
    start = n_wr_acc;
    cyc   = 0;
    while ((n_wr_acc - start) < 40 && cyc < 2000) begin
      wr_en = 1'($urandom_range(0, 1));
      rd_en = 1'($urandom_range(0, 1));
      wdata = 8'($urandom);
      tick();
      cyc++;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("rand_write_budget", 32'((n_wr_acc - start) >= 40), 32'd1);
    rd_en = 1'b1;
    repeat (10) tick();
    rd_en = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rand_drained", 32'(bus_t.count), 32'd0);

    // Sustained throughput at count=4
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1;
      wdata = 8'(8'h10 + i);
      tick();
    end
    for (int i = 0; i < 100; i++) begin
      wr_en = 1'b1;
      rd_en = 1'b1;
      wdata = 8'(8'h40 + i);
      tick();
      @(negedge clk);
      if (i >= 1) begin
        check("stream_rvalid_f", 32'(bus_f.rvalid), 32'd1);
        check("stream_rvalid_t", 32'(bus_t.rvalid), 32'd1);
      end
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    repeat (4) tick();
    rd_en = 1'b0;
    repeat (3) tick();

    // Reset one cycle after a read accept, count=5, overflow set
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1;
      wdata = 8'(8'h20 + i);
      tick();
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    check("pre_rst_count", 32'(bus_f.count),    32'd5);
    check("pre_rst_ovf",   32'(bus_f.overflow), 32'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_rvalid_f", 32'(bus_f.rvalid), 32'd0);
    check("rst_rvalid_t", 32'(bus_t.rvalid), 32'd0);
    check("rst_count_t",  32'(bus_t.count),  32'd0);
    check("rst_empty_t",  32'(bus_t.empty),  32'd1);
    check("rst_ovf_t",    32'(bus_t.overflow), 32'd0);
    check("rst_rdata_t",  32'(bus_t.rdata),  32'd0);
    tick();
    @(negedge clk);
    check("rst_late_rvalid_t", 32'(bus_t.rvalid), 32'd0);

    wr_en = 1'b1;
    wdata = 8'h3C;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    @(negedge clk);
    check("post_rst_rvalid_f", 32'(bus_f.rvalid), 32'd1);
    check("post_rst_rdata_f",  32'(bus_f.rdata),  32'h3C);
    tick();
    @(negedge clk);
    check("post_rst_rvalid_t", 32'(bus_t.rvalid), 32'd1);
    check("post_rst_rdata_t",  32'(bus_t.rdata),  32'h3C);
    repeat (3) tick();
    @(negedge clk);
    check("scoreboard_left_f", 32'(exp_f.size()), 32'd0);
    check("scoreboard_left_t", 32'(exp_t.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
